// File: rtl/pwm_multi_if.sv
// Control/duty-write bus and PWM outputs of pwm_multi.
// master drives control and duty writes; slave is the PWM generator.
interface pwm_multi_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PSC_W    = 8,
  parameter int CH_W     = 2
);
  logic                en;
  logic [PSC_W-1:0]    prescale;
  logic [WIDTH-1:0]    period;
  logic                center_mode;
  logic                wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic [WIDTH-1:0]    wr_duty;
  logic [CHANNELS-1:0] pwm_out;
  logic                period_tick;

  modport master (
    output en, prescale, period, center_mode, wr_en, wr_ch, wr_duty,
    input  pwm_out, period_tick
  );

  modport slave (
    input  en, prescale, period, center_mode, wr_en, wr_ch, wr_duty,
    output pwm_out, period_tick
  );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler and edge/center-aligned period counter, double-buffered duties.
// pwm_out is registered one clk after cnt; period_tick is high the clk after each boundary.
module pwm_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PSC_W    = 8,
  parameter int CH_W     = 2
) (
  input logic        clk,
  input logic        rst,
  pwm_multi_if.slave bus
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [PSC_W-1:0]    r_psc;
  logic [PSC_W-1:0]    w_psc_nxt;
  logic [WIDTH-1:0]    r_cnt;
  logic [WIDTH-1:0]    w_cnt_nxt;
  dir_t                r_dir;
  dir_t                w_dir_nxt;
  logic                w_tick;
  logic                w_boundary;
  logic [WIDTH-1:0]    r_period_a;
  logic                r_mode_a;
  logic [WIDTH-1:0]    r_shadow [CHANNELS];
  logic [WIDTH-1:0]    r_active [CHANNELS];
  logic [CHANNELS-1:0] r_pwm;
  logic                r_period_tick;

  always_comb begin
    w_psc_nxt  = r_psc;
    w_cnt_nxt  = r_cnt;
    w_dir_nxt  = r_dir;
    w_tick     = 1'b0;
    w_boundary = 1'b0;
    if (!bus.en) begin
      w_psc_nxt = '0;
      w_cnt_nxt = '0;
      w_dir_nxt = DIR_UP;
    end else begin
      // psc above a freshly lowered prescale keeps counting and wraps through its maximum
      if (r_psc == bus.prescale) begin
        w_psc_nxt = '0;
        w_tick    = 1'b1;
      end else begin
        w_psc_nxt = r_psc + 1'b1;
      end
      if (w_tick) begin
        if (!r_mode_a) begin
          if (r_cnt == r_period_a) begin
            w_cnt_nxt  = '0;
            w_boundary = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else if (r_dir == DIR_UP) begin
          if (r_cnt < r_period_a) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end else if (r_period_a > WIDTH'(1)) begin
            w_cnt_nxt = r_period_a - 1'b1;
            w_dir_nxt = DIR_DOWN;
          end else begin
            w_cnt_nxt  = '0;
            w_boundary = 1'b1;
          end
        end else begin
          if (r_cnt <= WIDTH'(1)) begin
            w_cnt_nxt  = '0;
            w_boundary = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        if (w_boundary) begin
          w_dir_nxt = DIR_UP;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_psc         <= '0;
      r_cnt         <= '0;
      r_dir         <= DIR_UP;
      r_period_a    <= '0;
      r_mode_a      <= 1'b0;
      r_pwm         <= '0;
      r_period_tick <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_psc         <= w_psc_nxt;
      r_cnt         <= w_cnt_nxt;
      r_dir         <= w_dir_nxt;
      r_period_tick <= w_boundary;
      // While stopped the active set tracks the inputs so the first period after enable uses them
      if (!bus.en || w_boundary) begin
        r_period_a <= bus.period;
        r_mode_a   <= bus.center_mode;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        r_pwm[i] <= bus.en && (r_cnt < r_active[i]);
        if (!bus.en || w_boundary) begin
          r_active[i] <= r_shadow[i];
        end
        if (bus.wr_en && (bus.wr_ch == CH_W'(i))) begin
          r_shadow[i] <= bus.wr_duty;
        end
      end
    end
  end

  assign bus.pwm_out     = r_pwm;
  assign bus.period_tick = r_period_tick;

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: directed scenarios plus random traffic against a period-position reference model.
module tb_pwm_multi;
  localparam int WIDTH = 8;
  localparam int CHANNELS = 4;
  localparam int PSC_W = 8;
  localparam int CH_W = 3;

  logic clk;
  logic rst;

  pwm_multi_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .PSC_W(PSC_W), .CH_W(CH_W)) bus ();

  pwm_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .PSC_W(PSC_W), .CH_W(CH_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference: position k within the period; cnt is derived from k, period length from P and mode.
  int m_psc, m_k, m_pa, m_ma;
  int m_sh [CHANNELS];
  int m_ac [CHANNELS];
  logic [CHANNELS-1:0] m_pwm;
  logic m_tick;

  function automatic int plen(input int p, input int m);
    if (p == 0) return 1;
    return (m != 0) ? 2 * p : p + 1;
  endfunction

  function automatic int pcnt(input int k, input int p, input int m);
    return (m != 0 && k > p) ? 2 * p - k : k;
  endfunction

  task automatic model_reset();
    m_psc = 0; m_k = 0; m_pa = 0; m_ma = 0;
    m_pwm = '0; m_tick = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      m_sh[i] = 0;
      m_ac[i] = 0;
    end
  endtask

  task automatic model_step();
    int c;
    bit tk;
    c = pcnt(m_k, m_pa, m_ma);
    for (int i = 0; i < CHANNELS; i++) m_pwm[i] = bus.en && (c < m_ac[i]);
    m_tick = 1'b0;
    if (!bus.en) begin
      m_psc = 0;
      m_k = 0;
      for (int i = 0; i < CHANNELS; i++) m_ac[i] = m_sh[i];
      m_pa = int'(bus.period);
      m_ma = int'(bus.center_mode);
    end else begin
      tk = (m_psc == int'(bus.prescale));
      m_psc = tk ? 0 : (m_psc + 1) % (1 << PSC_W);
      if (tk) begin
        if (m_k == plen(m_pa, m_ma) - 1) begin
          m_k = 0;
          m_tick = 1'b1;
          for (int i = 0; i < CHANNELS; i++) m_ac[i] = m_sh[i];
          m_pa = int'(bus.period);
          m_ma = int'(bus.center_mode);
        end else begin
          m_k++;
        end
      end
    end
    if (bus.wr_en && int'(bus.wr_ch) < CHANNELS) m_sh[bus.wr_ch] = int'(bus.wr_duty);
  endtask

  int hi [CHANNELS];
  int nt;

  task automatic clr();
    for (int i = 0; i < CHANNELS; i++) hi[i] = 0;
    nt = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    check("pwm_out", 32'(bus.pwm_out), 32'(m_pwm));
    check("period_tick", 32'(bus.period_tick), 32'(m_tick));
    for (int i = 0; i < CHANNELS; i++) hi[i] += int'(bus.pwm_out[i]);
    nt += int'(bus.period_tick);
  endtask

  task automatic do_wr(input int ch, input int d);
    bus.wr_en = 1'b1;
    bus.wr_ch = CH_W'(ch);
    bus.wr_duty = WIDTH'(d);
    cyc();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.period_tick && n < 100);
    if (!bus.period_tick) check("wait_tick_timeout", 0, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.en = 1'b0; bus.prescale = '0; bus.period = '0; bus.center_mode = 1'b0;
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_duty = '0;
    model_reset();
    clr();
    repeat (2) cyc();
    check("reset_pwm", 32'(bus.pwm_out), 0);
    check("reset_tick", 32'(bus.period_tick), 0);
    rst = 1'b0;

    // Async reset mid-period while ch0 is driving high
    bus.period = 8'd9;
    do_wr(0, 3);
    cyc();
    bus.en = 1'b1;
    repeat (13) cyc();
    n = 0;
    while (!bus.pwm_out[0] && n < 20) begin
      cyc();
      n++;
    end
    check("pre_arst_pwm0", 32'(bus.pwm_out[0]), 1);
    @(posedge clk);
    model_step();
    #2 rst = 1'b1;
    #1;
    check("arst_pwm", 32'(bus.pwm_out), 0);
    check("arst_tick", 32'(bus.period_tick), 0);
    model_reset();
    @(negedge clk);
    cyc();
    rst = 1'b0;

    // Edge mode P=9, duties 3/0/10/9
    bus.en = 1'b0;
    do_wr(0, 3); do_wr(1, 0); do_wr(2, 10); do_wr(3, 9);
    cyc();
    bus.en = 1'b1;
    repeat (3) cyc();
    clr();
    repeat (40) cyc();
    check("edge_hi0", hi[0], 12);
    check("edge_hi1", hi[1], 0);
    check("edge_hi2", hi[2], 40);
    check("edge_hi3", hi[3], 36);
    check("edge_ticks", nt, 4);

    // Mid-period write, then a write on the period_tick clk
    wait_tick();
    repeat (4) cyc();
    do_wr(0, 7);
    wait_tick();
    clr();
    do_wr(0, 2);
    repeat (9) cyc();
    check("upd_hi0", hi[0], 7);
    check("upd_ticks", nt, 1);
    clr();
    repeat (10) cyc();
    check("late_hi0", hi[0], 2);
    do_wr(5, 1);
    wait_tick();
    wait_tick();
    clr();
    repeat (10) cyc();
    check("oor_hi0", hi[0], 2);
    check("oor_hi1", hi[1], 0);
    check("oor_hi2", hi[2], 10);
    check("oor_hi3", hi[3], 9);

    // Center mode P=4
    bus.center_mode = 1'b1;
    bus.period = 8'd4;
    do_wr(0, 2);
    do_wr(1, 5);
    wait_tick();
    wait_tick();
    clr();
    repeat (8) cyc();
    check("ctr_hi0", hi[0], 3);
    check("ctr_hi1", hi[1], 8);
    check("ctr_hi2", hi[2], 8);
    check("ctr_ticks", nt, 1);

    // Prescaled edge mode
    bus.center_mode = 1'b0;
    bus.period = 8'd3;
    bus.prescale = 8'd2;
    do_wr(0, 2);
    wait_tick();
    wait_tick();
    clr();
    repeat (12) cyc();
    check("psc_hi0", hi[0], 6);
    check("psc_ticks", nt, 1);

    // Reconfigure while stopped, first period must use the new values
    bus.en = 1'b0;
    bus.prescale = 8'd0;
    do_wr(0, 1);
    bus.period = 8'd5;
    bus.center_mode = 1'b1;
    repeat (2) cyc();
    bus.en = 1'b1;
    clr();
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.period_tick && n < 40);
    check("en_first_period", n, 10);
    check("en_hi0", hi[0], 1);

    // Random traffic
    for (int it = 0; it < 3000; it++) begin
      bus.en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 49) == 0) bus.prescale = PSC_W'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) bus.period = WIDTH'($urandom_range(0, 12));
      if ($urandom_range(0, 39) == 0) bus.center_mode = ~bus.center_mode;
      bus.wr_en = ($urandom_range(0, 3) == 0);
      bus.wr_ch = CH_W'($urandom_range(0, 7));
      bus.wr_duty = WIDTH'($urandom_range(0, 14));
      rst = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst = 1'b0;
    bus.wr_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Multi-channel PWM generator, the parametrised successor of the single-channel 4-bit PWM. One shared prescaler and period counter drive CHANNELS compare outputs. The counter runs edge-aligned (sawtooth) or center-aligned (triangle). Duty values are double-buffered and take effect only at a period boundary, so outputs never glitch. It sits between the register/control logic and the LED/motor output pins.

Parameters:
WIDTH, 8, bit width of the period counter, the period and the duty values
CHANNELS, 4, number of independent PWM outputs
PSC_W, 8, bit width of the clock prescaler
CH_W, 2, width of the channel index; must satisfy 2**CH_W >= CHANNELS

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
en  in  1  run enable
prescale  in  PSC_W  one count tick every prescale+1 clk
period  in  WIDTH  period value P; sampled into the active register at each boundary
center_mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled at each boundary
wr_en  in  1  duty write strobe
wr_ch  in  CH_W  target channel for the write
wr_duty  in  WIDTH  duty value to write into the shadow register
pwm_out  out  CHANNELS  registered PWM outputs
period_tick  out  1  one-clk pulse at each period boundary

Behaviour:
- Reset (asynchronous, any time, including mid-period): clears the prescaler, cnt, dir (up), all shadow and active duty registers, period_a and mode_a. pwm_out=0, period_tick=0.
- Writes: if wr_en=1 and wr_ch<CHANNELS, shadow[wr_ch] takes wr_duty on the next clk edge. Writes with wr_ch>=CHANNELS are ignored. Writes are accepted regardless of en.
- Prescaler: psc counts 0..prescale and asserts tick on the clk where psc==prescale, then wraps to 0. With prescale=0, tick is asserted every clk.
- Edge mode (mode_a=0):
  - On tick: if cnt==period_a, set cnt=0 and take a boundary; otherwise cnt+1.
  - Sequence is 0..P, i.e. P+1 ticks per period.
- Center mode (mode_a=1), on tick:
  - dir up, cnt<P: cnt+1.
  - dir up, cnt==P, P>1: cnt=P-1, dir=down.
  - dir down, cnt==1: cnt=0, dir=up, boundary.
  - dir up, cnt==P, P==1: cnt=0, boundary.
  - Sequence is 0..P, P-1..1, i.e. 2P ticks per period.
- P==0, either mode: every tick is a boundary and cnt stays 0.
- Boundary actions (same clk edge):
  - active[i]<=shadow[i] for all i, using the pre-write shadow value. A write landing on the boundary clk is applied at the following boundary.
  - period_a<=period, mode_a<=center_mode, dir<=up.
  - period_tick=1 for exactly one clk.
- Compare: pwm_out[i] is registered as en && (cnt < active[i]), one clk after cnt holds the value.
  - Edge mode: high ticks per period = min(d, P+1).
  - Center mode: high ticks per period = 0 if d=0, else min(2d-1, 2P). The pulse is symmetric about cnt=0.
  - d=0 gives constant low; d>P gives constant high.
- en=0:
  - psc, cnt and dir are held at 0/up; pwm_out=0; period_tick=0.
  - active, period_a and mode_a reload from shadow/period/center_mode every clk.
  - On en rising, the period starts at cnt=0 using the values loaded on the last en=0 clk.
- Changing prescale mid-period takes effect immediately. If psc>prescale, psc counts up and wraps through its maximum.

Test Plan:
1. Run edge mode (P=9, prescale=0, ch0 d=3), then assert rst for 1 clk mid-period -> pwm_out=0 and period_tick=0 immediately (asynchronous). After release the pattern restarts from cnt=0.
2. Edge mode, P=9, prescale=0, ch0 d=3, ch1 d=0, ch2 d=10, ch3 d=9 -> ch0 high 3 of every 10 clk; ch1 always 0; ch2 always 1; ch3 high 9 of 10. period_tick every 10 clk.
3. Running as in 2, write ch0 d=7 at cnt=4, and separately write on the period_tick clk -> ch0 keeps 3/10 until the next boundary, then 7/10. The boundary-clk write appears one period later. Write with wr_ch=5 (CHANNELS=4) -> no change.
4. Center mode, P=4, d=2 -> cnt sequence 0,1,2,3,4,3,2,1 repeating. pwm_out high for 3 of 8 clk, centred on cnt=0. d=5 -> constant high.
5. prescale=2, edge mode, P=3, d=2 -> one tick per 3 clk; high 6 of 12 clk; period_tick every 12 clk.
6. en=0 while writing shadow and changing period and center_mode, then en=1 -> the first period uses the new values with no extra boundary delay.
